// File: rtl/proc_pkg.sv
// Shared types and constants for the memory stage: datapath widths, the
// memory-access FSM state encoding and the M->W pipeline bundle.
package proc_pkg;

    localparam int PKG_WIDTH  = 22;
    localparam int PKG_REG_AW = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic                  pc_src;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  bus_err;
        logic [PKG_WIDTH-1:0]  alu_result;
        logic [PKG_WIDTH-1:0]  read_data;
        logic [PKG_REG_AW-1:0] wa;
    } mw_bundle_t;

endpackage

// File: rtl/mem_wb_reg.sv
// M->W pipeline register: captures the memory-stage bundle when the stage
// advances, and inserts a bubble (control cleared, data held) while stalled.
module mem_wb_reg
    import proc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stall_i,
    input  mw_bundle_t d_i,
    output mw_bundle_t q_o
);

    mw_bundle_t q_q;
    mw_bundle_t q_d;

    // Next-state: capture on advance, bubble the control bits on stall.
    always_comb begin
        q_d = q_q;
        if (stall_i) begin
            q_d.pc_src     = 1'b0;
            q_d.reg_write  = 1'b0;
            q_d.mem_to_reg = 1'b0;
            q_d.bus_err    = 1'b0;
        end else begin
            q_d = d_i;
        end
    end

    // Pipeline register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/memory_stage_ctrl.sv
// Memory stage: req/ack data-memory FSM with pipeline stall and M->W register.
// Optional access timeout with bus-error reporting is enabled by MEM_TIMEOUT_EN.
module memory_stage_ctrl
    import proc_pkg::*;
#(
    // Bundle widths follow proc_pkg; change the package constants, not these.
    parameter int WIDTH          = PKG_WIDTH,
    parameter int REG_AW         = PKG_REG_AW,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_src_m,
    input  logic              reg_write_m,
    input  logic              mem_write_m,
    input  logic              mem_to_reg_m,
    input  logic [WIDTH-1:0]  alu_result_m,
    input  logic [WIDTH-1:0]  write_data_m,
    input  logic [REG_AW-1:0] wa_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic              stall_m,
    output logic              pc_src_w,
    output logic              reg_write_w,
    output logic              mem_to_reg_w,
    output logic [WIDTH-1:0]  alu_result_w,
    output logic [WIDTH-1:0]  read_data_w,
    output logic [REG_AW-1:0] wa_w,
    output logic              bus_err_w
);

    mem_state_t       state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             access_s;
    logic             done_s;
    logic             timeout_s;
    logic             stall_s;
    mw_bundle_t       wb_next_s;
    mw_bundle_t       wb_cur_s;

    assign access_s = mem_write_m | mem_to_reg_m;
    assign done_s   = (state_q == WAIT) & mem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // An ack in the last allowed cycle wins over the timeout.
    assign timeout_s = (state_q == WAIT) & ~mem_ack & (tmo_cnt_q == CNT_LAST);

    // Timeout counter next-state: count unanswered WAIT cycles, clear otherwise.
    always_comb begin
        tmo_cnt_d = '0;
        if ((state_q == WAIT) && !mem_ack && !timeout_s) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_d = '0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Reset releases the stall at once so the frozen front end is not held.
    assign stall_s = ~rst & (((state_q == IDLE) & access_s) |
                             ((state_q == WAIT) & ~mem_ack & ~timeout_s));
    assign stall_m = stall_s;

    // Access FSM next-state and memory-interface latching.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (access_s) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_write_m;
                    mem_addr_d  = alu_result_m;
                    mem_wdata_d = write_data_m;
                    state_d     = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (mem_ack || timeout_s) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // FSM and memory-interface registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Bundle offered to writeback; load data only changes when an access ends.
    always_comb begin
        wb_next_s.pc_src     = pc_src_m;
        wb_next_s.reg_write  = reg_write_m;
        wb_next_s.mem_to_reg = mem_to_reg_m;
        wb_next_s.bus_err    = 1'b0;
        wb_next_s.alu_result = alu_result_m;
        wb_next_s.read_data  = wb_cur_s.read_data;
        wb_next_s.wa         = wa_m;
        if (timeout_s) begin
            wb_next_s.reg_write  = 1'b0;
            wb_next_s.mem_to_reg = 1'b0;
            wb_next_s.read_data  = '0;
            wb_next_s.bus_err    = 1'b1;
        end else if (done_s) begin
            wb_next_s.read_data = mem_we_q ? '0 : mem_rdata;
        end else begin
            wb_next_s.read_data = wb_cur_s.read_data;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk_i   (clk),
        .rst_i   (rst),
        .stall_i (stall_s),
        .d_i     (wb_next_s),
        .q_o     (wb_cur_s)
    );

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign pc_src_w     = wb_cur_s.pc_src;
    assign reg_write_w  = wb_cur_s.reg_write;
    assign mem_to_reg_w = wb_cur_s.mem_to_reg;
    assign alu_result_w = wb_cur_s.alu_result;
    assign read_data_w  = wb_cur_s.read_data;
    assign wa_w         = wb_cur_s.wa;
    assign bus_err_w    = wb_cur_s.bus_err;

endmodule

// File: tb/tb_memory_stage_ctrl.sv
// Scoreboard bench for memory_stage_ctrl: a driver issues instructions and
// pushes the expected writeback bundle; a monitor pops and compares.
module tb_memory_stage_ctrl;

    localparam int W  = 22;
    localparam int RA = 4;
    localparam int TC = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk, rst;
    logic          pc_src_m, reg_write_m, mem_write_m, mem_to_reg_m;
    logic [W-1:0]  alu_result_m, write_data_m, mem_rdata;
    logic [RA-1:0] wa_m;
    logic          mem_req, mem_we, mem_ack, stall_m;
    logic [W-1:0]  mem_addr, mem_wdata, alu_result_w, read_data_w;
    logic          pc_src_w, reg_write_w, mem_to_reg_w, bus_err_w;
    logic [RA-1:0] wa_w;

    memory_stage_ctrl #(.WIDTH(W), .REG_AW(RA), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .rst(rst),
        .pc_src_m(pc_src_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
        .mem_to_reg_m(mem_to_reg_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .wa_m(wa_m), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_m(stall_m),
        .pc_src_w(pc_src_w), .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w),
        .alu_result_w(alu_result_w), .read_data_w(read_data_w), .wa_w(wa_w), .bus_err_w(bus_err_w)
    );

    typedef struct {
        logic          pc, rw, mr, be;
        logic [W-1:0]  alu, rd;
        logic [RA-1:0] wa;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] m_rd;
    int           errors = 0;
    int           checks = 0;
    bit           drv_done = 1'b0;
    bit           was_free = 1'b0;
    exp_t         mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_nop();
        pc_src_m = 1'b0; reg_write_m = 1'b0; mem_write_m = 1'b0; mem_to_reg_m = 1'b0;
        alu_result_m = '0; write_data_m = '0; wa_m = '0;
    endtask

    task automatic push_nop();
        exp_t e;
        e.pc = 1'b0; e.rw = 1'b0; e.mr = 1'b0; e.be = 1'b0;
        e.alu = '0; e.rd = m_rd; e.wa = '0;
        exp_q.push_back(e);
    endtask

    // Issue one instruction; dly = unanswered WAIT cycles before ack.
    task automatic issue(input logic pc, input logic rw, input logic mw, input logic mr,
                         input logic [W-1:0] alu, input logic [W-1:0] wd, input logic [RA-1:0] wa,
                         input int dly, input logic [W-1:0] rd, input bit noack, input int abort_at);
        exp_t e;
        bit   acc, tmo;
        int   stalls, exp_stalls;
        acc   = mw | mr;
        tmo   = acc && noack && TMO_EN;
        e.pc  = pc;
        e.rw  = rw && !tmo;
        e.mr  = mr && !tmo;
        e.be  = tmo;
        e.alu = alu;
        e.wa  = wa;
        e.rd  = !acc ? m_rd : ((tmo || mw) ? '0 : rd);
        exp_stalls = !acc ? 0 : (noack ? TC : dly + 1);
        @(posedge clk); #1;
        pc_src_m = pc; reg_write_m = rw; mem_write_m = mw; mem_to_reg_m = mr;
        alu_result_m = alu; write_data_m = wd; wa_m = wa;
        exp_q.push_back(e);
        m_rd   = e.rd;
        stalls = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (acc && !noack && cyc == dly + 1) begin
                mem_ack = 1'b1; mem_rdata = rd;
            end else begin
                mem_ack   = (cyc == 0) && ($urandom_range(0, 3) == 0);
                mem_rdata = W'($urandom);
            end
            #1;
            if (cyc == 0) chk("req_idle", 64'(mem_req), 64'(0));
            else chk("req_wait", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'({1'b1, mw, alu, wd}));
            if (stall_m) stalls++;
            if (cyc == abort_at) begin
                chk("stall_run", 64'(stalls), 64'(cyc + 1));
                return;
            end
            if (!stall_m) break;
        end
        chk("stall_cycles", 64'(stalls), 64'(exp_stalls));
    endtask

    // Assert reset in the middle of an access and restart from a clean pipe.
    task automatic reset_mid();
        rst = 1'b1; #1;
        chk("rst_req_stall", 64'({mem_req, stall_m}), 64'(0));
        chk("rst_w_ctrl", 64'({pc_src_w, reg_write_w, mem_to_reg_w, bus_err_w}), 64'(0));
        chk("rst_w_data", 64'({alu_result_w, read_data_w, wa_w}), 64'(0));
        exp_q.delete();
        m_rd = '0;
        drive_nop();
        mem_ack = 1'b1; mem_rdata = 22'h3FFFF;
        @(posedge clk); #1;
        rst = 1'b0;
        push_nop();
        #1;
        chk("post_rst_stall", 64'(stall_m), 64'(0));
    endtask

    // Monitor: W holds a new instruction after each non-stalled edge, a bubble otherwise.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                was_free = 1'b0;
            end else begin
                if (was_free) begin
                    if (exp_q.size() > 0) begin
                        mon_e = exp_q.pop_front();
                        chk("w_ctrl", 64'({pc_src_w, reg_write_w, mem_to_reg_w, bus_err_w}),
                            64'({mon_e.pc, mon_e.rw, mon_e.mr, mon_e.be}));
                        chk("w_alu", 64'(alu_result_w), 64'(mon_e.alu));
                        chk("w_rdata", 64'(read_data_w), 64'(mon_e.rd));
                        chk("w_wa", 64'(wa_w), 64'(mon_e.wa));
                    end else if (!drv_done) begin
                        checks++;
                        errors++;
                        $display("FAIL w_unexpected: got capture expected none");
                    end
                end else begin
                    chk("w_bubble", 64'({pc_src_w, reg_write_w, mem_to_reg_w, bus_err_w}), 64'(0));
                end
                was_free = !stall_m;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit   nk;
        int   kind;
        rst = 1'b1;
        drive_nop();
        mem_ack = 1'b0; mem_rdata = '0;
        m_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem", 64'({mem_req, mem_we, mem_addr, mem_wdata, stall_m}), 64'(0));
        chk("reset_w", 64'({pc_src_w, reg_write_w, mem_to_reg_w, bus_err_w, alu_result_w, read_data_w, wa_w}), 64'(0));
        push_nop();
        rst = 1'b0;

        issue(1'b0, 1'b1, 1'b0, 1'b0, 22'h00ABC, 22'h00000, 4'h3, 0, 22'h00000, 1'b0, -1);
        issue(1'b0, 1'b1, 1'b0, 1'b1, 22'h00010, 22'h00000, 4'h5, 3, 22'h3F00F, 1'b0, -1);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 22'h00123, 22'h00000, 4'h6, 0, 22'h00000, 1'b0, -1);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 22'h00020, 22'h12345, 4'h7, 1, 22'h2AAAA, 1'b0, -1);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 22'h00030, 22'h0BEEF, 4'h8, 0, 22'h15555, 1'b0, -1);
        issue(1'b0, 1'b1, 1'b0, 1'b1, 22'h00040, 22'h00000, 4'h2, 0, 22'h0C0DE, 1'b0, -1);
`ifdef MEM_TIMEOUT_EN
        issue(1'b0, 1'b1, 1'b0, 1'b1, 22'h00050, 22'h00000, 4'h9, 0, 22'h00000, 1'b1, -1);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 22'h00055, 22'h00000, 4'h1, 0, 22'h00000, 1'b0, -1);
`else
        issue(1'b0, 1'b1, 1'b0, 1'b1, 22'h00050, 22'h00000, 4'h9, 0, 22'h00000, 1'b1, 49);
        reset_mid();
`endif
        issue(1'b0, 1'b1, 1'b0, 1'b1, 22'h00060, 22'h00000, 4'hA, 0, 22'h00000, 1'b1, 2);
        reset_mid();

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            nk   = 1'b0;
            if (TMO_EN && kind != 0 && $urandom_range(0, 7) == 0) nk = 1'b1;
            issue(1'($urandom), 1'($urandom), kind >= 2, kind == 1 || kind == 3,
                  W'($urandom), W'($urandom), RA'($urandom), $urandom_range(0, TC - 1),
                  W'($urandom), nk, -1);
        end

        @(posedge clk); #1;
        drv_done = 1'b1;
        drive_nop();
        mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
